bg_fade_ctrl: RTL and testbench

Frame-synchronous brightness sequencer placed between the background palette lookup and the video output mux. On a one-cycle start request (goal scored, round reset) it fades the palette output to black, holds black for a fixed number of frames, then fades back to full brightness. Colour scaling is a 1-cycle pixel pipeline. The brightness level changes only on frame boundaries, so no tearing occurs mid-frame.

---
 rtl/bg_fade_ctrl.sv | 172 +++++++++++++++++
 tb/tb_bg_fade_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bg_fade_ctrl.sv
// Frame-synchronous background brightness sequencer: fade to black, hold, fade back.
// Level changes only on vsync rising edges; colour scaling is a 1-cycle registered pipeline.
module bg_fade_ctrl #(
    parameter int unsigned STEP_FRAMES = 2,
    parameter int unsigned HOLD_FRAMES = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync,
    input  logic       start_fade,
    input  logic [3:0] red_in,
    input  logic [3:0] green_in,
    input  logic [3:0] blue_in,
    input  logic       de_in,
    output logic [3:0] red_out,
    output logic [3:0] green_out,
    output logic [3:0] blue_out,
    output logic       de_out,
    output logic [4:0] level,
    output logic       busy,
    output logic       black_pulse,
    output logic       done_pulse
);

    localparam int unsigned STEP_W = $clog2(STEP_FRAMES + 1);
    localparam int unsigned HOLD_W = $clog2(HOLD_FRAMES + 1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_FADE_OUT = 2'd1;
    localparam logic [1:0] ST_HOLD     = 2'd2;
    localparam logic [1:0] ST_FADE_IN  = 2'd3;

    localparam logic [4:0] LEVEL_MAX = 5'd16;

    logic [1:0]        state_q, state_d;
    logic [4:0]        level_q, level_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              vsync_q, vsync_d;
    logic              busy_q, busy_d;
    logic              black_pulse_q, black_pulse_d;
    logic              done_pulse_q, done_pulse_d;
    logic [3:0]        red_q, red_d;
    logic [3:0]        green_q, green_d;
    logic [3:0]        blue_q, blue_d;
    logic              de_q, de_d;

    logic              tick;
    logic [STEP_W-1:0] step_inc;
    logic [HOLD_W-1:0] hold_inc;
    logic [8:0]        prod_r, prod_g, prod_b;

    assign tick     = vsync & ~vsync_q;
    assign step_inc = step_q + STEP_W'(1);
    assign hold_inc = hold_q + HOLD_W'(1);

    // Sequencer next-state and control outputs
    always_comb begin
        state_d       = state_q;
        level_d       = level_q;
        step_d        = step_q;
        hold_d        = hold_q;
        black_pulse_d = 1'b0;
        done_pulse_d  = 1'b0;
        vsync_d       = vsync;

        case (state_q)
            ST_IDLE: begin
                level_d = LEVEL_MAX;
                step_d  = '0;
                hold_d  = '0;
                if (start_fade) begin
                    state_d = ST_FADE_OUT;
                end
            end
            ST_FADE_OUT: begin
                if (tick) begin
                    if (step_inc == STEP_W'(STEP_FRAMES)) begin
                        step_d  = '0;
                        level_d = level_q - 5'd1;
                        if (level_q == 5'd1) begin
                            state_d       = ST_HOLD;
                            hold_d        = '0;
                            black_pulse_d = 1'b1;
                        end
                    end else begin
                        step_d = step_inc;
                    end
                end
            end
            ST_HOLD: begin
                level_d = 5'd0;
                if (tick) begin
                    if (hold_inc == HOLD_W'(HOLD_FRAMES)) begin
                        state_d = ST_FADE_IN;
                        hold_d  = '0;
                        step_d  = '0;
                    end else begin
                        hold_d = hold_inc;
                    end
                end
            end
            default: begin
                if (tick) begin
                    if (step_inc == STEP_W'(STEP_FRAMES)) begin
                        step_d  = '0;
                        level_d = level_q + 5'd1;
                        if (level_q == 5'd15) begin
                            state_d      = ST_IDLE;
                            done_pulse_d = 1'b1;
                        end
                    end else begin
                        step_d = step_inc;
                    end
                end
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Pixel scaling: (c * level) >> 4, level 16 is unity
    always_comb begin
        prod_r  = 9'(red_in)   * 9'(level_q);
        prod_g  = 9'(green_in) * 9'(level_q);
        prod_b  = 9'(blue_in)  * 9'(level_q);
        red_d   = 4'(prod_r >> 4);
        green_d = 4'(prod_g >> 4);
        blue_d  = 4'(prod_b >> 4);
        de_d    = de_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            level_q       <= LEVEL_MAX;
            step_q        <= '0;
            hold_q        <= '0;
            vsync_q       <= 1'b0;
            busy_q        <= 1'b0;
            black_pulse_q <= 1'b0;
            done_pulse_q  <= 1'b0;
            red_q         <= 4'd0;
            green_q       <= 4'd0;
            blue_q        <= 4'd0;
            de_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            level_q       <= level_d;
            step_q        <= step_d;
            hold_q        <= hold_d;
            vsync_q       <= vsync_d;
            busy_q        <= busy_d;
            black_pulse_q <= black_pulse_d;
            done_pulse_q  <= done_pulse_d;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
            de_q          <= de_d;
        end
    end

    assign red_out     = red_q;
    assign green_out   = green_q;
    assign blue_out    = blue_q;
    assign de_out      = de_q;
    assign level       = level_q;
    assign busy        = busy_q;
    assign black_pulse = black_pulse_q;
    assign done_pulse  = done_pulse_q;

endmodule

// File: tb/tb_bg_fade_ctrl.sv
// Directed bench for bg_fade_ctrl: a fast (1/2) instance and a default (2/30) instance.
module tb_bg_fade_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       vsync;
    logic       start_a, start_b;
    logic [3:0] red_in, green_in, blue_in;
    logic       de_in;

    logic [3:0] red_a, green_a, blue_a, red_b, green_b, blue_b;
    logic       de_a, de_b, busy_a, busy_b, black_a, black_b, done_a, done_b;
    logic [4:0] level_a, level_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bg_fade_ctrl #(.STEP_FRAMES(1), .HOLD_FRAMES(2)) dut_a (
        .clk(clk), .reset(reset), .vsync(vsync), .start_fade(start_a),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in), .de_in(de_in),
        .red_out(red_a), .green_out(green_a), .blue_out(blue_a), .de_out(de_a),
        .level(level_a), .busy(busy_a), .black_pulse(black_a), .done_pulse(done_a)
    );

    bg_fade_ctrl #(.STEP_FRAMES(2), .HOLD_FRAMES(30)) dut_b (
        .clk(clk), .reset(reset), .vsync(vsync), .start_fade(start_b),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in), .de_in(de_in),
        .red_out(red_b), .green_out(green_b), .blue_out(blue_b), .de_out(de_b),
        .level(level_b), .busy(busy_b), .black_pulse(black_b), .done_pulse(done_b)
    );

    // One vsync rising edge; returns at the negedge just after the edge that sees it.
    task automatic tick();
        @(negedge clk) vsync = 1'b1;
        @(negedge clk) vsync = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_start_a();
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; vsync = 1'b0; start_a = 1'b0; start_b = 1'b0;
        red_in = 4'd9; green_in = 4'd9; blue_in = 4'd9; de_in = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (level_a !== 5'd16 || busy_a !== 1'b0 || black_a !== 1'b0 || done_a !== 1'b0 ||
            red_a !== 4'd0 || de_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: level=%0d busy=%b black=%b done=%b red=%0d de=%b, want 16 0 0 0 0 0",
                     level_a, busy_a, black_a, done_a, red_a, de_a);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (red_a !== 4'd9 || green_a !== 4'd9 || blue_a !== 4'd9 || de_a !== 1'b1 ||
            busy_a !== 1'b0 || black_a !== 1'b0 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL passthrough: rgb=%0d,%0d,%0d de=%b busy=%b black=%b done=%b, want 9,9,9 1 0 0 0",
                     red_a, green_a, blue_a, de_a, busy_a, black_a, done_a);
        end
        de_in = 1'b0;
    endtask

    task automatic test_fade_half();
        pulse_start_a();
        checks++;
        if (busy_a !== 1'b1 || level_a !== 5'd16) begin
            errors++;
            $display("FAIL start_busy: busy=%b level=%0d, want 1 16", busy_a, level_a);
        end
        ticks(8);
        checks++;
        if (level_a !== 5'd8) begin
            errors++;
            $display("FAIL level_after_8: got %0d want 8", level_a);
        end
        red_in = 4'd7; green_in = 4'd3; blue_in = 4'd1; de_in = 1'b1;
        @(negedge clk);
        checks++;
        if (red_a !== 4'd3 || green_a !== 4'd1 || blue_a !== 4'd0 || de_a !== 1'b1) begin
            errors++;
            $display("FAIL scale_half: rgb=%0d,%0d,%0d de=%b, want 3,1,0 1", red_a, green_a, blue_a, de_a);
        end
        de_in = 1'b0;
    endtask

    task automatic test_black_and_return();
        ticks(7);
        checks++;
        if (level_a !== 5'd1 || black_a !== 1'b0) begin
            errors++;
            $display("FAIL level_after_15: level=%0d black=%b, want 1 0", level_a, black_a);
        end
        tick();
        checks++;
        if (level_a !== 5'd0 || black_a !== 1'b1) begin
            errors++;
            $display("FAIL black_reached: level=%0d black=%b, want 0 1", level_a, black_a);
        end
        @(negedge clk);
        checks++;
        if (black_a !== 1'b0) begin
            errors++;
            $display("FAIL black_one_cycle: black=%b want 0", black_a);
        end
        ticks(2);
        checks++;
        if (level_a !== 5'd0 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL hold_exit: level=%0d busy=%b, want 0 1", level_a, busy_a);
        end
        ticks(15);
        checks++;
        if (level_a !== 5'd15 || busy_a !== 1'b1 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL level_15_in: level=%0d busy=%b done=%b, want 15 1 0", level_a, busy_a, done_a);
        end
        tick();
        checks++;
        if (level_a !== 5'd16 || done_a !== 1'b1 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL done_reached: level=%0d done=%b busy=%b, want 16 1 0", level_a, done_a, busy_a);
        end
        @(negedge clk);
        checks++;
        if (done_a !== 1'b0) begin
            errors++;
            $display("FAIL done_one_cycle: done=%b want 0", done_a);
        end
    endtask

    task automatic test_vsync_held_and_ignored_start();
        pulse_start_a();
        tick();
        @(negedge clk) vsync = 1'b1;
        repeat (100) @(negedge clk);
        vsync = 1'b0;
        @(negedge clk);
        checks++;
        if (level_a !== 5'd14) begin
            errors++;
            $display("FAIL vsync_held: level=%0d want 14", level_a);
        end
        ticks(14);
        checks++;
        if (level_a !== 5'd0) begin
            errors++;
            $display("FAIL reach_hold: level=%0d want 0", level_a);
        end
        pulse_start_a();
        checks++;
        if (level_a !== 5'd0 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL start_in_hold: level=%0d busy=%b, want 0 1", level_a, busy_a);
        end
        ticks(18);
        checks++;
        if (level_a !== 5'd16 || done_a !== 1'b1 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL complete_after_ignore: level=%0d done=%b busy=%b, want 16 1 0",
                     level_a, done_a, busy_a);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL start_not_queued: busy=%b want 0", busy_a);
        end
    endtask

    task automatic test_reset_abort();
        pulse_start_a();
        ticks(11);
        checks++;
        if (level_a !== 5'd5) begin
            errors++;
            $display("FAIL level_5: got %0d want 5", level_a);
        end
        red_in = 4'd15; green_in = 4'd15; blue_in = 4'd15; de_in = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (level_a !== 5'd16 || busy_a !== 1'b0 || red_a !== 4'd0 || de_a !== 1'b0 ||
            done_a !== 1'b0 || black_a !== 1'b0) begin
            errors++;
            $display("FAIL abort: level=%0d busy=%b red=%0d de=%b done=%b black=%b, want 16 0 0 0 0 0",
                     level_a, busy_a, red_a, de_a, done_a, black_a);
        end
        reset = 1'b0; de_in = 1'b0;
        @(negedge clk);
        checks++;
        if (done_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_pulse: done=%b busy=%b, want 0 0", done_a, busy_a);
        end
    endtask

    task automatic test_start_with_tick();
        @(negedge clk) begin start_a = 1'b1; vsync = 1'b1; end
        @(negedge clk) begin start_a = 1'b0; vsync = 1'b0; end
        checks++;
        if (busy_a !== 1'b1 || level_a !== 5'd16) begin
            errors++;
            $display("FAIL start_tick_coincident: busy=%b level=%0d, want 1 16", busy_a, level_a);
        end
        tick();
        checks++;
        if (level_a !== 5'd15) begin
            errors++;
            $display("FAIL first_step_after_coincident: level=%0d want 15", level_a);
        end
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic test_defaults();
        int black_at = -1;
        int done_at  = -1;
        int bad_lvl  = 0;
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        for (int t = 1; t <= 100 && done_at < 0; t++) begin
            tick();
            if (level_b > 5'd16) bad_lvl++;
            if (black_b === 1'b1) black_at = t;
            if (done_b === 1'b1) done_at = t;
        end
        checks++;
        if (black_at !== 32) begin
            errors++;
            $display("FAIL default_black_tick: got %0d want 32", black_at);
        end
        checks++;
        if (done_at !== 94) begin
            errors++;
            $display("FAIL default_done_tick: got %0d want 94", done_at);
        end
        checks++;
        if (bad_lvl !== 0 || level_b !== 5'd16 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL default_level_range: bad=%0d level=%0d busy=%b, want 0 16 0", bad_lvl, level_b, busy_b);
        end
        checks++;
        if (level_a !== 5'd16 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL idle_ticks: level=%0d busy=%b, want 16 0", level_a, busy_a);
        end
    endtask

    initial begin
        test_reset();
        test_fade_half();
        test_black_and_return();
        test_vsync_held_and_ignored_start();
        test_reset_abort();
        test_start_with_tick();
        test_defaults();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
